// File: rtl/fp32_serial_host_pkg.sv
// Shared definitions for the fp32 serial host: widths, FSM encoding and FP32 field positions
// also used by the add_float bench.
package fp32_serial_host_pkg;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 60;
    localparam int SER_BITS = 2 * WIDTH;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SEND   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam logic [5:0] LAST_BIT  = 6'(SER_BITS - 1);
    localparam logic [5:0] WAIT_LAST = 6'(MAX_WAIT - 1);

    // True while a serial counter sits on its terminal value
    function automatic logic cnt_at(input logic [5:0] cnt, input logic [5:0] last);
        return (cnt == last);
    endfunction

endpackage

// File: rtl/fp32_serial_host_if.sv
// Serial link between the host driver and the bit-serial add_float core.
interface fp32_serial_host_if;
    logic go;
    logic inpab;
    logic shift;
    logic out_c;
    logic over;
    logic under;
    logic done;

    modport master (output go, output inpab,
                    input shift, input out_c, input over, input under, input done);
    modport slave  (input go, input inpab,
                    output shift, output out_c, output over, output under, output done);
endinterface

// File: rtl/fp32_serial_host_piso.sv
// Parallel-in serial-out shift register, MSB first, with load and shift enable.
module fp32_serial_host_piso #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sh_r;

    // Shift register: load has priority over shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r <= '0;
        end else if (load) begin
            sh_r <= din;
        end else if (shift_en) begin
            sh_r <= {sh_r[W-2:0], 1'b0};
        end else begin
            sh_r <= sh_r;
        end
    end

    assign msb = sh_r[W-1];

endmodule

// File: rtl/fp32_serial_host.sv
// Host-side driver for the bit-serial add_float core: sends A then B MSB-first, collects the
// serial sum and reports over/under/timeout with a one-cycle valid pulse.
module fp32_serial_host
    import fp32_serial_host_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic [WIDTH-1:0]     result,
    output logic                 res_valid,
    output logic                 res_over,
    output logic                 res_under,
    output logic                 timeout,
    fp32_serial_host_if.master   core
);

    state_e      state_r, state_s;
    logic [5:0]  bit_cnt_r, bit_cnt_s;
    logic [5:0]  wait_cnt_r, wait_cnt_s;
    logic        go_r, go_s;
    logic        inpab_r, inpab_s;
    logic        busy_r, busy_s;
    logic        res_valid_r, res_valid_s;
    logic        over_r, over_s;
    logic        under_r, under_s;
    logic        timeout_r, timeout_s;
    logic        load_s, shen_s, piso_msb_s;
    logic [WIDTH-1:0] result_r;

    fp32_serial_host_piso #(.W(SER_BITS)) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .shift_en (shen_s),
        .din      ({op_a, op_b}),
        .msb      (piso_msb_s)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 6'd0;
            wait_cnt_r  <= 6'd0;
            go_r        <= 1'b1;
            inpab_r     <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            over_r      <= 1'b0;
            under_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            go_r        <= go_s;
            inpab_r     <= inpab_s;
            busy_r      <= busy_s;
            res_valid_r <= res_valid_s;
            over_r      <= over_s;
            under_r     <= under_s;
            timeout_r   <= timeout_s;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        go_s        = go_r;
        inpab_s     = 1'b0;
        busy_s      = busy_r;
        res_valid_s = 1'b0;
        over_s      = over_r;
        under_s     = under_r;
        timeout_s   = timeout_r;
        load_s      = 1'b0;
        shen_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                go_s   = 1'b1;
                busy_s = 1'b0;
                if (start) begin
                    state_s    = ST_ARM;
                    load_s     = 1'b1;
                    go_s       = 1'b0;
                    busy_s     = 1'b1;
                    over_s     = 1'b0;
                    under_s    = 1'b0;
                    timeout_s  = 1'b0;
                    bit_cnt_s  = 6'd0;
                    wait_cnt_s = 6'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // inpab is registered, so the first bit is fetched during the go-low setup cycle
            ST_ARM: begin
                state_s   = ST_SEND;
                shen_s    = 1'b1;
                inpab_s   = piso_msb_s;
                bit_cnt_s = 6'd0;
            end
            ST_SEND: begin
                if (cnt_at(bit_cnt_r, LAST_BIT)) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = 6'd0;
                end else begin
                    shen_s    = 1'b1;
                    inpab_s   = piso_msb_s;
                    bit_cnt_s = bit_cnt_r + 6'd1;
                end
            end
            ST_WAIT: begin
                if (core.done) begin
                    state_s     = ST_FINISH;
                    over_s      = core.over;
                    under_s     = core.under;
                    res_valid_s = 1'b1;
                    go_s        = 1'b1;
                    busy_s      = 1'b0;
                end else if (cnt_at(wait_cnt_r, WAIT_LAST)) begin
                    state_s     = ST_FINISH;
                    timeout_s   = 1'b1;
                    res_valid_s = 1'b1;
                    go_s        = 1'b1;
                    busy_s      = 1'b0;
                end else begin
                    wait_cnt_s = wait_cnt_r + 6'd1;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
                go_s    = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                go_s    = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Result SIPO: the core may begin shifting out while operands are still being sent
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= '0;
        end else if (((state_r == ST_SEND) || (state_r == ST_WAIT)) && core.shift) begin
            result_r <= {result_r[WIDTH-2:0], core.out_c};
        end else begin
            result_r <= result_r;
        end
    end

    assign core.go    = go_r;
    assign core.inpab = inpab_r;
    assign busy       = busy_r;
    assign result     = result_r;
    assign res_valid  = res_valid_r;
    assign res_over   = over_r;
    assign res_under  = under_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_fp32_serial_host.sv
// Directed bench for fp32_serial_host with a behavioural add_float core that replays scripted sums.
module tb_fp32_serial_host;
    import fp32_serial_host_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        busy, res_valid, res_over, res_under, timeout;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    // Core model script: shift window start (cycle index from the go-low cycle), length, bits
    int          m_start = 66;
    int          m_len = 32;
    logic [63:0] m_word = 64'h0;
    bit          m_done_en = 1'b1;
    logic        m_over = 1'b0;
    logic        m_under = 1'b0;
    int          t = -1;
    logic [5:0]  m_idx;

    fp32_serial_host_if bus ();

    fp32_serial_host dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .result    (result),
        .res_valid (res_valid),
        .res_over  (res_over),
        .res_under (res_under),
        .timeout   (timeout),
        .core      (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural core: counts cycles since go fell and drives the scripted serial sum
    always @(negedge clk) begin
        if (reset || bus.go !== 1'b0) begin
            t = -1;
            bus.shift = 1'b0; bus.out_c = 1'b0; bus.done = 1'b0;
            bus.over = 1'b0;  bus.under = 1'b0;
        end else begin
            t = t + 1;
            if (t >= m_start && t < m_start + m_len) begin
                m_idx = 6'(m_len - 1 - (t - m_start));
                bus.shift = 1'b1;
                bus.out_c = m_word[m_idx];
                bus.done  = m_done_en && (t == m_start + m_len - 1);
            end else begin
                bus.shift = 1'b0; bus.out_c = 1'b0; bus.done = 1'b0;
            end
            bus.over  = m_over;
            bus.under = m_under;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; lat returns the negedge count after start at which res_valid was seen
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int abort_at,
                           input bit inject, output int lat, output logic [63:0] stream);
        bit go_low;
        go_low = 1'b1;
        stream = 64'h0;
        lat = 0;
        @(negedge clk);
        chk("idle_go", 64'(bus.go), 64'd1);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arm", 64'({bus.go, bus.inpab, busy, timeout}), 64'b0010);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            stream = {stream[62:0], bus.inpab};
            if (bus.go !== 1'b0) go_low = 1'b0;
            if (k == abort_at) begin
                reset = 1'b1;
                return;
            end
            if (inject && k == 8) begin
                op_a = ~a; op_b = ~b; start = 1'b1;
            end else if (inject && k == 9) begin
                start = 1'b0;
                chk("busy_ignore", 64'(busy), 64'd1);
            end
        end
        chk("go_low", 64'(go_low), 64'd1);
        chk("stream", stream, {a, b});
        lat = 65;
        while (res_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [63:0] stream;
        bit seen;

        // 1. reset held 100 ns, then idle with no start
        #100;
        @(negedge clk);
        chk("rst_state", 64'({bus.go, busy, res_valid}), 64'b100);
        chk("rst_result", 64'(result), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_static", 64'({bus.go, bus.inpab, busy, res_valid, timeout, res_over,
                                    res_under, result}), 64'({1'b1, 6'b0, 32'h0}));
        end

        // 2. done on the last shift pulse
        m_start = 66; m_len = 32; m_word = 64'h0000_0000_3FE0_0000; m_done_en = 1'b1;
        m_over = 1'b0; m_under = 1'b0;
        run_txn(32'h3F600000, 32'h3F600000, -1, 1'b0, lat, stream);
        chk("t2_lat", 64'(lat), 64'd99);
        chk("t2_result", 64'(result), 64'h3FE00000);
        chk("t2_flags", 64'({res_over, res_under, timeout}), 64'b000);
        chk("t2_go_busy", 64'({bus.go, busy}), 64'b10);
        @(negedge clk);
        chk("t2_pulse", 64'(res_valid), 64'd0);

        // 3. cancellation: shifting starts while B is still being sent
        m_start = 50; m_len = 32; m_word = 64'h0; m_under = 1'b1;
        run_txn(32'h3F600000, 32'hBF600000, -1, 1'b0, lat, stream);
        chk("t3_lat", 64'(lat), 64'd83);
        chk("t3_flags", 64'({res_over, res_under, timeout}), 64'b010);
        chk("t3_result", 64'(result), 64'h0);
        chk("t3_sign", 64'(result[SIGN_BIT]), 64'd0);

        // 4. overflow with 36 shift pulses: only the last 32 bits survive
        m_start = 66; m_len = 36; m_word = 64'h0000_000A_7F80_0000;
        m_under = 1'b0; m_over = 1'b1;
        run_txn(32'h7F7FFFFF, 32'h7F7FFFFF, -1, 1'b0, lat, stream);
        chk("t4_lat", 64'(lat), 64'd103);
        chk("t4_flags", 64'({res_over, res_under, timeout}), 64'b100);
        chk("t4_result", 64'(result), 64'h7F800000);
        chk("t4_exp", 64'(result[EXP_MSB:EXP_LSB]), 64'hFF);
        chk("t4_man", 64'(result[MAN_MSB:0]), 64'h0);

        // 5. done never arrives; over from the core must not be captured
        m_len = 0; m_done_en = 1'b0; m_over = 1'b1;
        run_txn(32'h3F800000, 32'h40000000, -1, 1'b0, lat, stream);
        chk("t5_lat", 64'(lat), 64'd126);
        chk("t5_flags", 64'({res_over, res_under, timeout}), 64'b001);
        chk("t5_go_busy", 64'({bus.go, busy}), 64'b10);
        chk("t5_result", 64'(result), 64'h7F800000);

        // 6. reset during SEND bit 20 aborts; then a clean transaction with a stray start
        m_start = 66; m_len = 32; m_word = 64'h0000_0000_4040_0000; m_done_en = 1'b1;
        m_over = 1'b0;
        run_txn(32'h40000000, 32'h3F800000, 20, 1'b0, lat, stream);
        @(negedge clk);
        chk("t6_abort", 64'({bus.go, busy, res_valid}), 64'b100);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = 1'b1;
        end
        chk("t6_no_valid", 64'(seen), 64'd0);
        run_txn(32'h40000000, 32'h3F800000, -1, 1'b1, lat, stream);
        chk("t6_lat", 64'(lat), 64'd99);
        chk("t6_result", 64'(result), 64'h40400000);
        chk("t6_flags", 64'({res_over, res_under, timeout}), 64'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
